// File: rtl/library_pkg.sv
// Shared types and default sizing for the slotted coordinate library writer.
package library_pkg;

    localparam int COORD_W_DEF  = 5;
    localparam int SLOT_W_DEF   = 5;
    localparam int NUM_SLOTS_DEF = 26;
    localparam int OFFSET_W_DEF = 11;
    localparam int ADDR_W_DEF   = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WORK   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Default-width (x,y) sample as delivered by the coordinate front-end.
    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
    } coord_pair_t;

endpackage

// File: rtl/library_len_table.sv
// Per-slot committed record length table: one synchronous write port,
// one combinational read port that returns zero for slots outside the library.
module library_len_table
    import library_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int SLOT_W    = SLOT_W_DEF,
    parameter int LEN_W     = OFFSET_W_DEF + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [SLOT_W-1:0] i_waddr,
    input  logic [LEN_W-1:0]  i_wdata,
    input  logic [SLOT_W-1:0] i_raddr,
    output logic [LEN_W-1:0]  o_rdata
);

    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W+1)'(NUM_SLOTS);

    logic [LEN_W-1:0] mem_q [NUM_SLOTS];

    // Length storage with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= {LEN_W{1'b0}};
            end
        end else if (i_we && ({1'b0, i_waddr} < SLOT_LIMIT)) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Readback sees pre-update contents during a same-cycle write.
    always_comb begin
        o_rdata = {LEN_W{1'b0}};
        if ({1'b0, i_raddr} < SLOT_LIMIT) begin
            o_rdata = mem_q[i_raddr];
        end else begin
            o_rdata = {LEN_W{1'b0}};
        end
    end

endmodule

// File: rtl/library_store_multi.sv
// Streams (x,y) samples into slotted library memory, one record per slot,
// with saturation, zero-length discard, commit pulse and length readback.
module library_store_multi
    import library_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int SLOT_W    = SLOT_W_DEF,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int OFFSET_W  = OFFSET_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_hold,
    input  logic                i_valid,
    input  logic [COORD_W-1:0]  i_x,
    input  logic [COORD_W-1:0]  i_y,
    input  logic [SLOT_W-1:0]   i_rd_slot,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [COORD_W-1:0]  o_x,
    output logic [COORD_W-1:0]  o_y,
    output logic                o_done,
    output logic [SLOT_W-1:0]   o_done_slot,
    output logic [OFFSET_W:0]   o_done_len,
    output logic                o_ovf,
    output logic [OFFSET_W:0]   o_rd_len
);

    localparam int CNT_W = OFFSET_W + 1;
    localparam logic [CNT_W-1:0]  CAP       = {1'b1, {OFFSET_W{1'b0}}};
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    state_e               state_q;
    logic [SLOT_W-1:0]    slot_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 wr_en_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic                 done_q;
    logic [SLOT_W-1:0]    done_slot_q;
    logic [CNT_W-1:0]     done_len_q;
    logic                 ovf_q;

    logic                 accept_s;
    logic                 sat_s;
    logic                 commit_s;
    logic [SLOT_W-1:0]    slot_d;
    logic [ADDR_W-1:0]    addr_d;

    // Sample acceptance, commit qualification, next slot and write address.
    always_comb begin
        accept_s = 1'b0;
        sat_s    = 1'b0;
        commit_s = 1'b0;
        slot_d   = slot_q;
        addr_d   = {ADDR_W{1'b0}};
        if ((state_q == WORK) && i_hold && i_valid) begin
            if (cnt_q < CAP) begin
                accept_s = 1'b1;
            end else begin
                sat_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            sat_s    = 1'b0;
        end
        if ((state_q == COMMIT) && (cnt_q != {CNT_W{1'b0}})) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        if (slot_q == LAST_SLOT) begin
            slot_d = {SLOT_W{1'b0}};
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
        addr_d[SLOT_W+OFFSET_W-1:0] = {slot_q, cnt_q[OFFSET_W-1:0]};
    end

    // Record FSM with registered write port and commit outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            slot_q      <= {SLOT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            wr_en_q     <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            x_q         <= {COORD_W{1'b0}};
            y_q         <= {COORD_W{1'b0}};
            done_q      <= 1'b0;
            done_slot_q <= {SLOT_W{1'b0}};
            done_len_q  <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            wr_en_q <= accept_s;
            if (accept_s) begin
                addr_q <= addr_d;
                x_q    <= i_x;
                y_q    <= i_y;
            end
            done_q      <= commit_s;
            done_slot_q <= commit_s ? slot_q : {SLOT_W{1'b0}};
            done_len_q  <= commit_s ? cnt_q : {CNT_W{1'b0}};
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= WORK;
                        cnt_q   <= {CNT_W{1'b0}};
                        ovf_q   <= 1'b0;
                    end
                end
                WORK: begin
                    if (!i_hold) begin
                        state_q <= COMMIT;
                    end else if (accept_s) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (sat_s) begin
                        ovf_q <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    // Empty records keep their slot so the next one reuses it.
                    if (commit_s) begin
                        slot_q <= slot_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    library_len_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W),
        .LEN_W     (CNT_W)
    ) u_len_table (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (commit_s),
        .i_waddr (slot_q),
        .i_wdata (cnt_q),
        .i_raddr (i_rd_slot),
        .o_rdata (o_rd_len)
    );

    assign o_wr_en     = wr_en_q;
    assign o_addr      = addr_q;
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_done      = done_q;
    assign o_done_slot = done_slot_q;
    assign o_done_len  = done_len_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_library_store_multi.sv
// Self-checking bench: directed and randomized records against a
// record-level reference model of the library writer.
module tb_library_store_multi;

    localparam int COORD_W   = 5;
    localparam int SLOT_W    = 5;
    localparam int NUM_SLOTS = 26;
    localparam int OFFSET_W  = 11;
    localparam int ADDR_W    = 20;
    localparam int CAP       = 2048;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_start;
    logic                i_hold;
    logic                i_valid;
    logic [COORD_W-1:0]  i_x;
    logic [COORD_W-1:0]  i_y;
    logic [SLOT_W-1:0]   i_rd_slot;
    logic                o_wr_en;
    logic [ADDR_W-1:0]   o_addr;
    logic [COORD_W-1:0]  o_x;
    logic [COORD_W-1:0]  o_y;
    logic                o_done;
    logic [SLOT_W-1:0]   o_done_slot;
    logic [OFFSET_W:0]   o_done_len;
    logic                o_ovf;
    logic [OFFSET_W:0]   o_rd_len;

    library_store_multi #(
        .COORD_W   (COORD_W),
        .SLOT_W    (SLOT_W),
        .NUM_SLOTS (NUM_SLOTS),
        .OFFSET_W  (OFFSET_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_hold      (i_hold),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_rd_slot   (i_rd_slot),
        .o_wr_en     (o_wr_en),
        .o_addr      (o_addr),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_done      (o_done),
        .o_done_slot (o_done_slot),
        .o_done_len  (o_done_len),
        .o_ovf       (o_ovf),
        .o_rd_len    (o_rd_len)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: record phase (0 waiting, 1 recording, 2 closing),
    // current slot, samples stored in this record, and committed lengths.
    int m_phase;
    int m_slot;
    int m_cnt;
    bit m_ovf;
    int m_len [NUM_SLOTS];
    bit e_wr;
    int e_addr, e_x, e_y;
    bit e_done;
    int e_dslot, e_dlen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_rd(input int s);
        return (s < NUM_SLOTS) ? m_len[s] : 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_slot = 0; m_cnt = 0; m_ovf = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) m_len[i] = 0;
        e_wr = 1'b0; e_addr = 0; e_x = 0; e_y = 0;
        e_done = 1'b0; e_dslot = 0; e_dlen = 0;
    endtask

    task automatic check_outputs();
        chk("wr_en", o_wr_en, e_wr);
        chk("addr", o_addr, e_addr);
        chk("x", o_x, e_x);
        chk("y", o_y, e_y);
        chk("done", o_done, e_done);
        chk("done_slot", o_done_slot, e_dslot);
        chk("done_len", o_done_len, e_dlen);
        chk("ovf", o_ovf, m_ovf);
    endtask

    // One clock of stimulus: drive, check readback, predict, check after the edge.
    task automatic step(input bit st, input bit hd, input bit vl, input int x, input int y);
        i_start = st; i_hold = hd; i_valid = vl;
        i_x = x[COORD_W-1:0]; i_y = y[COORD_W-1:0];
        i_rd_slot = SLOT_W'($urandom_range(31, 0));
        #1;
        chk("rd_len", o_rd_len, model_rd(int'(i_rd_slot)));
        e_wr = 1'b0; e_done = 1'b0; e_dslot = 0; e_dlen = 0;
        case (m_phase)
            0: if (st) begin m_phase = 1; m_cnt = 0; m_ovf = 1'b0; end
            1: begin
                if (!hd) m_phase = 2;
                else if (vl) begin
                    if (m_cnt < CAP) begin
                        e_wr = 1'b1; e_addr = m_slot * CAP + m_cnt;
                        e_x = x; e_y = y; m_cnt++;
                    end else m_ovf = 1'b1;
                end
            end
            default: begin
                if (m_cnt > 0) begin
                    m_len[m_slot] = m_cnt;
                    e_done = 1'b1; e_dslot = m_slot; e_dlen = m_cnt;
                    m_slot = (m_slot + 1) % NUM_SLOTS;
                end
                m_phase = 0;
            end
        endcase
        @(posedge i_clk); #1;
        check_outputs();
    endtask

    // Full record: start, hold for samples, closing cycle, commit, idle.
    task automatic run_rec(input int nvalid, input int min_cyc, input bit seq, input bit noisy);
        int got = 0;
        int cyc = 0;
        bit v;
        int x, y;
        step(1'b1, 1'b1, 1'b0, 0, 0);
        while (got < nvalid || cyc < min_cyc) begin
            v = (got < nvalid) && (noisy ? ($urandom_range(3, 0) != 0) : 1'b1);
            x = seq ? 2 * got + 1 : int'($urandom_range(31, 0));
            y = seq ? 2 * got + 2 : int'($urandom_range(31, 0));
            step(noisy ? 1'($urandom_range(1, 0)) : 1'b0, 1'b1, v, x, y);
            if (v) got++;
            cyc++;
        end
        step(noisy, 1'b0, noisy, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        step(noisy, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic reset_now();
        i_rst = 1'b1;
        i_start = 1'b0; i_hold = 1'b0; i_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        i_rd_slot = '0;
        #1;
        chk("rst_rd_len0", o_rd_len, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_hold = 1'b0; i_valid = 1'b0;
        i_x = '0; i_y = '0; i_rd_slot = '0;
        #3;
        reset_now();

        run_rec(3, 0, 1'b1, 1'b0);
        i_rd_slot = '0; #1;
        chk("basic_rd0", o_rd_len, 32'd3);
        run_rec(1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) run_rec(1, 0, 1'b0, 1'b0);
        i_rd_slot = '0; #1;
        chk("wrap_rd0", o_rd_len, 32'd1);

        run_rec(0, 4, 1'b0, 1'b0);
        run_rec(2, 0, 1'b0, 1'b1);

        run_rec(CAP + 4, 0, 1'b0, 1'b0);
        chk("sat_ovf_sticky", o_ovf, 32'd1);
        run_rec(1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run_rec(int'($urandom_range(6, 0)), int'($urandom_range(2, 0)), 1'b0, 1'b1);
        end

        step(1'b1, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 7, 9);
        step(1'b0, 1'b1, 1'b1, 11, 13);
        #2;
        reset_now();
        run_rec(2, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/library_store_multi.md
Name: library_store_multi

Overview:
- Parametrised successor to the single-channel library write-address generator.
- Streams (x,y) coordinate samples into a slotted library memory. Each record occupies one slot, and the slot index wraps at NUM_SLOTS.
- Adds the following over the previous generation: a registered write port, offset-overflow saturation, zero-length record discard, a per-slot length table with readback, and a commit pulse.
- Sits between the coordinate front-end and the library SRAM; the matcher reads record lengths through the readback port.

Parameters:
- COORD_W, 5: width of each coordinate.
- SLOT_W, 5: width of the slot index.
- NUM_SLOTS, 26: number of slots in use; must be <= 2**SLOT_W.
- OFFSET_W, 11: sample offset width inside a slot; capacity is 2**OFFSET_W samples.
- ADDR_W, 20: memory address width; must be >= SLOT_W+OFFSET_W.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  request a new record; honoured only in IDLE.
- i_hold  in  1  record continues while high; a low level in WORK ends the record.
- i_valid  in  1  a sample is present on i_x/i_y this cycle.
- i_x  in  COORD_W  sample x.
- i_y  in  COORD_W  sample y.
- i_rd_slot  in  SLOT_W  slot index for length readback.
- o_wr_en  out  1  registered memory write strobe.
- o_addr  out  ADDR_W  registered write address: zero-extended {slot, offset}.
- o_x  out  COORD_W  registered write data x.
- o_y  out  COORD_W  registered write data y.
- o_done  out  1  one-cycle commit pulse.
- o_done_slot  out  SLOT_W  slot just committed; valid with o_done.
- o_done_len  out  OFFSET_W+1  sample count just committed; valid with o_done.
- o_ovf  out  1  sticky; set when the current record saturated; cleared on next i_start accept.
- o_rd_len  out  OFFSET_W+1  length-table entry for i_rd_slot; combinational read.

Behaviour:
- Reset (i_rst high, asynchronous):
  - state=IDLE, slot=0, offset count=0.
  - All length-table entries=0.
  - All outputs 0.
- Reset mid-record discards the record; the length table is not updated.
- IDLE -> WORK when i_start=1. On that edge: count cleared, o_ovf cleared.
- WORK, i_hold=1:
  - Each cycle with i_valid=1 and count < 2**OFFSET_W is an accepted sample.
  - Next cycle: o_wr_en=1, o_addr={slot,count[OFFSET_W-1:0]}, o_x/o_y = sampled i_x/i_y. Latency is 1 cycle.
  - count increments after each accepted sample.
- Otherwise o_wr_en=0. o_addr, o_x and o_y hold their last values.
- Saturation: when i_valid=1 and count == 2**OFFSET_W, the sample is dropped, o_wr_en=0, o_ovf=1, and count stays saturated.
- WORK, i_hold=0 -> COMMIT. A sample with i_valid in that same cycle is ignored.
- COMMIT, one cycle, then -> IDLE:
  - If count>0: len_table[slot]=count, o_done=1, o_done_slot=slot, o_done_len=count.
  - Slot advances: slot = (slot==NUM_SLOTS-1) ? 0 : slot+1.
  - If count==0: no table write, no o_done, slot unchanged.
- o_done, o_done_slot and o_done_len are registered. They appear the cycle after COMMIT and are 0 when o_done=0.
- i_start in WORK or COMMIT is ignored; there is no queuing.
- A pending registered write from the last accepted sample completes in the COMMIT cycle regardless of state change.
- Length-table read during a same-cycle update returns the old value.
- If i_rd_slot >= NUM_SLOTS, o_rd_len=0.
- Widths: count is OFFSET_W+1 bits so the full capacity is representable. Address fields are zero-extended, never truncated.

Decomposition:
- Package library_pkg:
  - state enum {IDLE, WORK, COMMIT}.
  - Default parameter constants.
  - Typedef for the coordinate pair struct.
- Sub-module library_len_table:
  - NUM_SLOTS x (OFFSET_W+1) register array.
  - One write port, one asynchronous read port.
  - Async active-high clear on i_rst.

Test Plan:
- Basic record: start, hold=1, 3 valid samples (1,2),(3,4),(5,6), then hold=0 -> three writes at o_addr 0x0, 0x1, 0x2 with matching data one cycle after each sample. o_done=1 with slot=0, len=3. o_rd_len(0)=3. Next record writes from 0x800.
- Wrap: run 26 one-sample records -> slot 25 record at addr 25<<11 = 0xC800. The 27th record writes at 0x0 and overwrites len_table[0].
- Zero-length: start, hold=1 for 4 cycles, no valid, then hold=0 -> no o_wr_en, no o_done, slot unchanged, next record lands in the same slot.
- Overflow (OFFSET_W=2): 6 valid samples -> 4 writes at offsets 0..3, o_ovf=1, o_done_len=4. The next i_start clears o_ovf.
- Async reset mid-record after 2 samples -> all outputs 0 immediately, no o_done, o_rd_len(0)=0, slot=0.
- Ignored events: i_start pulse during WORK, and i_valid in the i_hold=0 cycle -> no extra record and no extra write; the count excludes the final-cycle sample.
